clock_enable_bank: RTL and testbench

Parametrised multi-channel clock-divider and strobe generator. It replaces the single fixed-divisor toggle divider in `neural_network_top` with N independent channels. Each channel has a runtime-loadable divisor, selects between a toggled square output and a one-cycle enable strobe, and reloads glitch-free at terminal count. A global sync realigns all channel phases. The strobe outputs let downstream logic (e.g. `neural_network`) run on `clk_in` with clock enables instead of fabric-derived clocks.

---
 rtl/clock_enable_bank.sv | 118 +++++++++++
 tb/tb_clock_enable_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_enable_bank.sv
// Multi-channel clock divider / strobe generator on a single clock.
// Each channel has a shadowed divisor and mode that are applied glitch-free at terminal count, while idle, or on sync.
module clock_enable_bank #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned CHAN_W       = 2,
    parameter int unsigned W            = 32,
    parameter int unsigned DEFAULT_DIV  = 500,
    parameter logic        DEFAULT_MODE = 1'b0
) (
    input  logic              clk_in,
    input  logic              resetn,
    input  logic [N_CH-1:0]   enable,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [W-1:0]      cfg_div,
    input  logic              cfg_mode,
    output logic [N_CH-1:0]   clk_out,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
);

    logic [W-1:0]    cnt        [N_CH];
    logic [W-1:0]    div_q      [N_CH];
    logic [W-1:0]    shadow_div [N_CH];
    logic [N_CH-1:0] mode_q;
    logic [N_CH-1:0] shadow_mode;
    logic [N_CH-1:0] running;
    logic [N_CH-1:0] terminal;
    logic [N_CH-1:0] accept;

    // Out-of-range channel selects match no channel, so they are always ready and go nowhere.
    always_comb begin
        cfg_ready = 1'b1;
        for (int c = 0; c < int'(N_CH); c++) begin
            if (cfg_chan == CHAN_W'(c)) begin
                cfg_ready = ~pending[c];
            end
        end
    end

    always_comb begin
        running  = '0;
        terminal = '0;
        accept   = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            running[c]  = enable[c] & (div_q[c] != '0);
            terminal[c] = running[c] & (cnt[c] == div_q[c] - W'(1));
            accept[c]   = cfg_valid & cfg_ready & (cfg_chan == CHAN_W'(c));
        end
    end

    always_ff @(posedge clk_in) begin
        if (!resetn) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                cnt[c]         <= '0;
                div_q[c]       <= W'(DEFAULT_DIV);
                shadow_div[c]  <= W'(DEFAULT_DIV);
                mode_q[c]      <= DEFAULT_MODE;
                shadow_mode[c] <= DEFAULT_MODE;
                clk_out[c]     <= 1'b0;
                tick[c]        <= 1'b0;
                pending[c]     <= 1'b0;
            end
        end else begin
            for (int c = 0; c < int'(N_CH); c++) begin
                tick[c] <= 1'b0;
                if (sync) begin
                    cnt[c]     <= '0;
                    clk_out[c] <= 1'b0;
                    if (pending[c]) begin
                        div_q[c]   <= shadow_div[c];
                        mode_q[c]  <= shadow_mode[c];
                        pending[c] <= 1'b0;
                    end
                end else if (!running[c]) begin
                    // Idle channel: hold phase, but a zero divisor forces everything low.
                    if (div_q[c] == '0) begin
                        cnt[c]     <= '0;
                        clk_out[c] <= 1'b0;
                    end
                    if (pending[c]) begin
                        div_q[c]   <= shadow_div[c];
                        mode_q[c]  <= shadow_mode[c];
                        pending[c] <= 1'b0;
                        cnt[c]     <= '0;
                        clk_out[c] <= 1'b0;
                    end
                end else if (terminal[c]) begin
                    cnt[c] <= '0;
                    if (mode_q[c]) begin
                        tick[c] <= 1'b1;
                    end else begin
                        clk_out[c] <= ~clk_out[c];
                    end
                    // Terminal action above uses the old mode; a switch to pulse parks clk_out low.
                    if (pending[c]) begin
                        div_q[c]   <= shadow_div[c];
                        mode_q[c]  <= shadow_mode[c];
                        pending[c] <= 1'b0;
                        if (shadow_mode[c]) begin
                            clk_out[c] <= 1'b0;
                        end
                    end
                end else begin
                    cnt[c] <= cnt[c] + W'(1);
                end
                if (accept[c]) begin
                    shadow_div[c]  <= cfg_div;
                    shadow_mode[c] <= cfg_mode;
                    pending[c]     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_enable_bank.sv
// Scoreboard bench for clock_enable_bank: expectations are queued with a due cycle
// when stimulus is driven and compared after the matching clock edge.
module tb_clock_enable_bank;

    logic        clk_in = 1'b0;
    logic        resetn;
    logic [3:0]  enable;
    logic        sync;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_chan;
    logic [31:0] cfg_div;
    logic        cfg_mode;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  pending;

    clock_enable_bank #(
        .N_CH(4), .CHAN_W(3), .W(32), .DEFAULT_DIV(500), .DEFAULT_MODE(1'b0)
    ) dut (
        .clk_in(clk_in), .resetn(resetn), .enable(enable), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
        .cfg_div(cfg_div), .cfg_mode(cfg_mode), .clk_out(clk_out),
        .tick(tick), .pending(pending)
    );

    always #5 clk_in = ~clk_in;

    localparam int K_CLK = 0;
    localparam int K_TICK = 1;
    localparam int K_PEND = 2;
    localparam int K_RDY = 3;

    typedef struct {
        string      tag;
        int         kind;
        logic [3:0] exp_v;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   t0 = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    function automatic logic [3:0] observe(input int kind);
        case (kind)
            K_CLK:   return clk_out;
            K_TICK:  return tick;
            K_PEND:  return pending;
            default: return {3'b000, cfg_ready};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [3:0] e, input int dt);
        exp_t x;
        x.tag   = tag;
        x.kind  = kind;
        x.exp_v = e;
        x.due   = t0 + dt;
        sb.push_back(x);
    endtask

    task automatic drain();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk(sb[i].tag, 32'(observe(sb[i].kind)), 32'(sb[i].exp_v));
                sb.delete(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        cyc++;
        drain();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        enable = '0;
        resetn = 1'b0;
        run(2);
        resetn = 1'b1;
    endtask

    // Load a disabled channel: accept on the first edge, applied on the second.
    task automatic load(input logic [2:0] ch, input logic [31:0] d, input logic m);
        cfg_valid = 1'b1;
        cfg_chan  = ch;
        cfg_div   = d;
        cfg_mode  = m;
        step();
        cfg_valid = 1'b0;
        step();
    endtask

    initial begin
        resetn = 1'b0; enable = '0; sync = 1'b0;
        cfg_valid = 1'b0; cfg_chan = '0; cfg_div = '0; cfg_mode = 1'b0;

        // Reset state
        t0 = cyc;
        push("rst_clk", K_CLK, 4'b0000, 2);
        push("rst_tick", K_TICK, 4'b0000, 2);
        push("rst_pend", K_PEND, 4'b0000, 2);
        push("rst_rdy", K_RDY, 4'b0001, 2);
        run(3);
        resetn = 1'b1;

        // Default divisor on channel 0
        enable = 4'b0001;
        t0 = cyc;
        push("def_pre_rise", K_CLK, 4'b0000, 499);
        push("def_rise", K_CLK, 4'b0001, 500);
        push("def_tick", K_TICK, 4'b0000, 500);
        push("def_hold", K_CLK, 4'b0001, 999);
        push("def_fall", K_CLK, 4'b0000, 1000);
        push("def_rise2", K_CLK, 4'b0001, 1500);
        run(1500);

        // Pulse mode on channel 1, loaded while disabled
        do_reset();
        t0 = cyc;
        push("pulse_pend_set", K_PEND, 4'b0010, 1);
        push("pulse_rdy_low", K_RDY, 4'b0000, 1);
        push("pulse_pend_clr", K_PEND, 4'b0000, 2);
        push("pulse_rdy_high", K_RDY, 4'b0001, 2);
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_div = 32'd3; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        enable = 4'b0010;
        t0 = cyc;
        push("pulse_t2", K_TICK, 4'b0000, 2);
        push("pulse_t3", K_TICK, 4'b0010, 3);
        push("pulse_t4", K_TICK, 4'b0000, 4);
        push("pulse_t5", K_TICK, 4'b0000, 5);
        push("pulse_t6", K_TICK, 4'b0010, 6);
        push("pulse_t9", K_TICK, 4'b0010, 9);
        push("pulse_clk", K_CLK, 4'b0000, 6);
        run(10);

        // Glitch-free reload of channel 0 from D=10 to D=4
        do_reset();
        load(3'd0, 32'd10, 1'b0);
        enable = 4'b0001;
        t0 = cyc;
        push("rl_pre", K_CLK, 4'b0000, 9);
        push("rl_rise", K_CLK, 4'b0001, 10);
        push("rl_pend", K_PEND, 4'b0001, 15);
        push("rl_rdy_low", K_RDY, 4'b0000, 15);
        push("rl_pend_hold", K_PEND, 4'b0001, 19);
        push("rl_rdy_hold", K_RDY, 4'b0000, 19);
        push("rl_old_half", K_CLK, 4'b0001, 19);
        push("rl_fall", K_CLK, 4'b0000, 20);
        push("rl_pend_clr", K_PEND, 4'b0000, 20);
        push("rl_rdy_back", K_RDY, 4'b0001, 20);
        push("rl_new_pre", K_CLK, 4'b0000, 23);
        push("rl_new_rise", K_CLK, 4'b0001, 24);
        push("rl_new_hold", K_CLK, 4'b0001, 27);
        push("rl_new_fall", K_CLK, 4'b0000, 28);
        push("rl_new_rise2", K_CLK, 4'b0001, 32);
        run(14);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 32'd4; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        run(20);

        // Edge divisors on channel 2: D=0, then D=1 toggle, then D=1 pulse
        do_reset();
        load(3'd2, 32'd0, 1'b0);
        enable = 4'b0100;
        t0 = cyc;
        push("d0_clk", K_CLK, 4'b0000, 3);
        push("d0_tick", K_TICK, 4'b0000, 3);
        push("d0_clk2", K_CLK, 4'b0000, 5);
        run(5);
        t0 = cyc;
        push("d1t_pend", K_PEND, 4'b0100, 1);
        push("d1t_pend_clr", K_PEND, 4'b0000, 2);
        push("d1t_apply", K_CLK, 4'b0000, 2);
        push("d1t_c3", K_CLK, 4'b0100, 3);
        push("d1t_c4", K_CLK, 4'b0000, 4);
        push("d1t_c5", K_CLK, 4'b0100, 5);
        cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 32'd1; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        run(4);
        t0 = cyc;
        push("d1p_c1", K_CLK, 4'b0000, 1);
        push("d1p_pend", K_PEND, 4'b0100, 1);
        push("d1p_c2", K_CLK, 4'b0000, 2);
        push("d1p_t2", K_TICK, 4'b0000, 2);
        push("d1p_pend_clr", K_PEND, 4'b0000, 2);
        push("d1p_t3", K_TICK, 4'b0100, 3);
        push("d1p_c3", K_CLK, 4'b0000, 3);
        push("d1p_t4", K_TICK, 4'b0100, 4);
        push("d1p_t6", K_TICK, 4'b0100, 6);
        push("d1p_c6", K_CLK, 4'b0000, 6);
        cfg_valid = 1'b1; cfg_chan = 3'd2; cfg_div = 32'd1; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        run(5);

        // Sync realigns channels 0 and 3 and applies the pending load on 3
        do_reset();
        load(3'd0, 32'd7, 1'b0);
        load(3'd3, 32'd7, 1'b0);
        enable = 4'b0001;
        t0 = cyc;
        push("sync_skew", K_CLK, 4'b0001, 8);
        run(3);
        enable = 4'b1001;
        run(5);
        t0 = cyc;
        push("sync_pend", K_PEND, 4'b1000, 1);
        push("sync_clk", K_CLK, 4'b0000, 2);
        push("sync_tick", K_TICK, 4'b0000, 2);
        push("sync_pend_clr", K_PEND, 4'b0000, 2);
        push("oor_rdy", K_RDY, 4'b0001, 3);
        push("oor_pend", K_PEND, 4'b0000, 3);
        push("oor_pend2", K_PEND, 4'b0000, 4);
        push("sync_pre", K_CLK, 4'b0000, 8);
        push("sync_rise", K_CLK, 4'b1001, 9);
        push("sync_hold", K_CLK, 4'b1001, 15);
        push("sync_fall", K_CLK, 4'b0000, 16);
        cfg_valid = 1'b1; cfg_chan = 3'd3; cfg_div = 32'd7; cfg_mode = 1'b0;
        step();
        cfg_valid = 1'b0;
        sync = 1'b1;
        step();
        sync = 1'b0;
        // Out-of-range channel select is accepted and dropped
        cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_div = 32'd2; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0; cfg_chan = 3'd0;
        run(20);

        // Reset while channel 0 has a pending load mid-count
        t0 = cyc;
        push("mid_pend", K_PEND, 4'b0001, 1);
        push("mid_clk", K_CLK, 4'b1001, 1);
        push("mrst_clk", K_CLK, 4'b0000, 2);
        push("mrst_tick", K_TICK, 4'b0000, 2);
        push("mrst_pend", K_PEND, 4'b0000, 2);
        push("mrst_rdy", K_RDY, 4'b0001, 2);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_div = 32'd3; cfg_mode = 1'b1;
        step();
        cfg_valid = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        t0 = cyc;
        push("post_pend", K_PEND, 4'b0000, 1);
        push("post_pre", K_CLK, 4'b0000, 499);
        push("post_rise", K_CLK, 4'b1001, 500);
        push("post_tick", K_TICK, 4'b0000, 500);
        run(501);

        if (sb.size() != 0) chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
